// File: rtl/exc_commit_ctrl_if.sv
// MEM-stage to CP0 exception bundle: instruction/exception inputs, forwarded CP0 state,
// and the exception record, flush and redirect outputs of the commit controller.
interface exc_commit_ctrl_if;
    logic        mem_valid_i;
    logic        mem_stall_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [5:0]  mem_exc_flags_i;     // {if_adel, ri, ov, sys, bp, eret}
    logic        mem_dadel_i;
    logic        mem_dades_i;
    logic [31:0] mem_addr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;

    logic        exception_occured_o;
    logic [4:0]  exc_code_o;
    logic [31:0] pc_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output mem_valid_i, mem_stall_i, mem_pc_i, mem_in_delayslot_i, mem_exc_flags_i,
               mem_dadel_i, mem_dades_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
        input  exception_occured_o, exc_code_o, pc_o, is_in_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );

    modport slave (
        input  mem_valid_i, mem_stall_i, mem_pc_i, mem_in_delayslot_i, mem_exc_flags_i,
               mem_dadel_i, mem_dades_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
        output exception_occured_o, exc_code_o, pc_o, is_in_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// MEM-stage exception commit controller: picks one exception by fixed priority, hands the
// record to CP0 in the same cycle, then flushes the pipeline and redirects fetch.
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2            // 1..15
) (
    input  logic             clk,
    input  logic             rst,
    exc_commit_ctrl_if.slave bus
);

    typedef enum logic {IDLE, FLUSH} state_e;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h10;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        int_pending_q, int_pending_d;

    logic        f_if_adel, f_ri, f_ov, f_sys, f_bp, f_eret;
    logic        int_req;
    logic        any_exc;
    logic        commit;
    logic [4:0]  win_code;
    logic [31:0] win_bad;

    assign {f_if_adel, f_ri, f_ov, f_sys, f_bp, f_eret} = bus.mem_exc_flags_i;

    // Interrupts are taken only with IE=1, EXL=0 and at least one unmasked pending IP line.
    assign int_req = bus.cp0_status_i[0] & ~bus.cp0_status_i[1]
                   & |(bus.cp0_cause_i[15:8] & bus.cp0_status_i[15:8]);

    assign any_exc = int_pending_q | (|bus.mem_exc_flags_i) | bus.mem_dadel_i | bus.mem_dades_i;

    // Gating with rst keeps the CP0-facing record at zero while reset is held.
    assign commit = rst & (state_q == IDLE) & bus.mem_valid_i & ~bus.mem_stall_i & any_exc;

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        win_code = EXC_INT;
        win_bad  = '0;
        if (int_pending_q)         win_code = EXC_INT;
        else if (f_if_adel) begin
            win_code = EXC_ADEL;
            win_bad  = bus.mem_pc_i;
        end
        else if (f_ri)             win_code = EXC_RI;
        else if (f_ov)             win_code = EXC_OV;
        else if (f_sys)            win_code = EXC_SYS;
        else if (f_bp)             win_code = EXC_BP;
        else if (bus.mem_dadel_i) begin
            win_code = EXC_ADEL;
            win_bad  = bus.mem_addr_i;
        end
        else if (bus.mem_dades_i) begin
            win_code = EXC_ADES;
            win_bad  = bus.mem_addr_i;
        end
        else if (f_eret)           win_code = EXC_ERET;
    end

    assign bus.exception_occured_o = commit;
    assign bus.exc_code_o          = commit ? win_code : 5'h00;
    assign bus.pc_o                = commit ? bus.mem_pc_i : 32'h0;
    assign bus.is_in_delayslot_o   = commit & bus.mem_in_delayslot_i;
    assign bus.bad_addr_o          = commit ? win_bad : 32'h0;
    assign bus.flush_o             = flush_q;
    assign bus.new_pc_o            = new_pc_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_d       = flush_q;
        new_pc_d      = new_pc_q;
        // Pending interrupt tracks int_req and is consumed by the commit that reports it.
        int_pending_d = int_req & ~(commit & int_pending_q);

        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    cnt_d    = FLUSH_INIT;
                    new_pc_d = (win_code == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            int_pending_q <= int_pending_d;
        end
    end

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                               bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: each driven cycle pushes its expected record,
// the negedge monitor pops and compares it against the DUT outputs.
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [5:0] F_ADEL = 6'b100000;
    localparam logic [5:0] F_RI   = 6'b010000;
    localparam logic [5:0] F_OV   = 6'b001000;
    localparam logic [5:0] F_SYS  = 6'b000100;
    localparam logic [5:0] F_BP   = 6'b000010;
    localparam logic [5:0] F_ERET = 6'b000001;

    typedef struct {
        logic        valid, stall, ds, dadel, dades;
        logic [31:0] pc, addr, status, cause, epc;
        logic [5:0]  flags;
    } stim_t;

    typedef struct {
        logic        occ, ds, flush, chk_npc;
        logic [4:0]  code;
        logic [31:0] pc, bad, npc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    n_checks = 0;
    int    n_fails  = 0;
    string cur_test = "reset";
    exp_t  sb_q[$];

    exc_commit_ctrl_if bus ();

    exc_commit_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s/%s: got 0x%08h, expected 0x%08h at %0t", cur_test, tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t s_bub();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t s_ins(input logic [31:0] pc, input logic [5:0] flags);
        stim_t s;
        s = s_bub();
        s.valid = 1'b1;
        s.pc    = pc;
        s.flags = flags;
        return s;
    endfunction

    function automatic exp_t e_none();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t e_flush(input logic [31:0] npc);
        exp_t e;
        e = e_none();
        e.flush = 1'b1;
        e.chk_npc = 1'b1;
        e.npc = npc;
        return e;
    endfunction

    function automatic exp_t e_commit(input logic [4:0] code, input logic [31:0] pc,
                                      input logic ds, input logic [31:0] bad);
        exp_t e;
        e = e_none();
        e.occ = 1'b1;
        e.code = code;
        e.pc = pc;
        e.ds = ds;
        e.bad = bad;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.mem_valid_i        = s.valid;
        bus.mem_stall_i        = s.stall;
        bus.mem_pc_i           = s.pc;
        bus.mem_in_delayslot_i = s.ds;
        bus.mem_exc_flags_i    = s.flags;
        bus.mem_dadel_i        = s.dadel;
        bus.mem_dades_i        = s.dades;
        bus.mem_addr_i         = s.addr;
        bus.cp0_status_i       = s.status;
        bus.cp0_cause_i        = s.cause;
        bus.cp0_epc_i          = s.epc;
    endtask

    task automatic cycle(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        sb_q.push_back(e);
    endtask

    task automatic flush_out(input logic [31:0] npc);
        cycle(s_bub(), e_flush(npc));
        cycle(s_bub(), e_flush(npc));
        cycle(s_bub(), e_none());
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("occured", 32'(bus.exception_occured_o), 32'(e.occ));
            check("code",    32'(bus.exc_code_o),          32'(e.code));
            check("pc",      bus.pc_o,                     e.pc);
            check("dslot",   32'(bus.is_in_delayslot_o),   32'(e.ds));
            check("bad",     bus.bad_addr_o,               e.bad);
            check("flush",   32'(bus.flush_o),             32'(e.flush));
            if (e.chk_npc) check("new_pc", bus.new_pc_o, e.npc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;

        // Reset held with a live exception on the inputs: everything must read zero.
        s = s_ins(32'h8000_0004, F_OV);
        apply(s);
        #12;
        check("occ_rst",   32'(bus.exception_occured_o), 32'd0);
        check("code_rst",  32'(bus.exc_code_o),          32'd0);
        check("flush_rst", 32'(bus.flush_o),             32'd0);
        check("npc_rst",   bus.new_pc_o,                 32'd0);
        apply(s_bub());
        @(negedge clk);
        #2 rst = 1'b1;

        cur_test = "ov_dslot";
        s = s_ins(32'h8000_0104, F_OV);
        s.ds = 1'b1;
        cycle(s, e_commit(5'h0c, 32'h8000_0104, 1'b1, 32'h0));
        flush_out(VEC);

        cur_test = "ri_over_dades";
        s = s_ins(32'h8000_0200, F_RI);
        s.dades = 1'b1;
        s.addr  = 32'h0000_0003;
        cycle(s, e_commit(5'h0a, 32'h8000_0200, 1'b0, 32'h0));
        flush_out(VEC);

        cur_test = "dades_alone";
        s = s_ins(32'h8000_0300, 6'b0);
        s.dades = 1'b1;
        s.addr  = 32'h0000_0003;
        cycle(s, e_commit(5'h05, 32'h8000_0300, 1'b0, 32'h0000_0003));
        flush_out(VEC);

        cur_test = "if_adel";
        s = s_ins(32'h8000_0401, F_ADEL | F_SYS);
        s.dadel = 1'b1;
        s.addr  = 32'h0000_1111;
        cycle(s, e_commit(5'h04, 32'h8000_0401, 1'b0, 32'h8000_0401));
        flush_out(VEC);

        cur_test = "dadel";
        s = s_ins(32'h8000_0410, F_ERET);
        s.dadel = 1'b1;
        s.addr  = 32'h0000_2222;
        cycle(s, e_commit(5'h04, 32'h8000_0410, 1'b0, 32'h0000_2222));
        flush_out(VEC);

        cur_test = "sys_over_bp";
        cycle(s_ins(32'h8000_0420, F_SYS | F_BP | F_ERET), e_commit(5'h08, 32'h8000_0420, 1'b0, 32'h0));
        flush_out(VEC);

        cur_test = "int_bubble";
        s = s_bub();
        s.status = 32'h0000_8001;
        s.cause  = 32'h0000_8000;
        repeat (3) cycle(s, e_none());
        s.valid = 1'b1;
        s.pc    = 32'h8000_0500;
        cycle(s, e_commit(5'h00, 32'h8000_0500, 1'b0, 32'h0));
        flush_out(VEC);
        cycle(s_ins(32'h8000_0504, 6'b0), e_none());

        cur_test = "int_masked_exl";
        s = s_ins(32'h8000_0510, 6'b0);
        s.status = 32'h0000_8003;
        s.cause  = 32'h0000_8000;
        repeat (2) cycle(s, e_none());

        cur_test = "int_dropped";
        s = s_bub();
        s.status = 32'h0000_8001;
        s.cause  = 32'h0000_8000;
        cycle(s, e_none());
        s.cause = 32'h0;
        cycle(s, e_none());
        cycle(s_ins(32'h8000_0520, 6'b0), e_none());

        cur_test = "int_over_eret";
        s = s_bub();
        s.status = 32'h0000_8001;
        s.cause  = 32'h0000_8000;
        cycle(s, e_none());
        s.valid = 1'b1;
        s.pc    = 32'h8000_0530;
        s.flags = F_ERET;
        s.epc   = 32'h8000_2000;
        cycle(s, e_commit(5'h00, 32'h8000_0530, 1'b0, 32'h0));
        flush_out(VEC);

        cur_test = "eret";
        s = s_ins(32'h8000_0600, F_ERET);
        s.epc = 32'h8000_2000;
        cycle(s, e_commit(5'h10, 32'h8000_0600, 1'b0, 32'h0));
        s = s_ins(32'h8000_0604, F_SYS);
        s.epc = 32'h1234_5678;
        cycle(s, e_flush(32'h8000_2000));
        cycle(s, e_flush(32'h8000_2000));
        cycle(s_bub(), e_none());

        cur_test = "stall_then_reset";
        s = s_ins(32'h8000_0700, F_SYS);
        s.stall = 1'b1;
        repeat (4) cycle(s, e_none());
        s.stall = 1'b0;
        cycle(s, e_commit(5'h08, 32'h8000_0700, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        apply(s_bub());
        check("flush_first", 32'(bus.flush_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("flush_async", 32'(bus.flush_o), 32'd0);
        check("npc_async",   bus.new_pc_o,     32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        cycle(s_bub(), e_none());
        cycle(s_ins(32'h8000_0800, F_OV), e_commit(5'h0c, 32'h8000_0800, 1'b0, 32'h0));
        flush_out(VEC);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
